// File: rtl/sdram_chip_model.sv
// sdram_chip_model: cycle-based SDR SDRAM device responder.
// Tracks open rows, mode register and bursts; serves data from a word array.
module sdram_chip_model #(
   parameter int ROW_W      = 13,
   parameter int COL_W      = 9,
   parameter int BANK_W     = 2,
   parameter int DATA_W     = 32,
   parameter int MEM_ADDR_W = 24
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  sdram_cke,
   input  logic                  sdram_cs,
   input  logic                  sdram_ras,
   input  logic                  sdram_cas,
   input  logic                  sdram_we,
   input  logic [ROW_W-1:0]      sdram_a,
   input  logic [BANK_W-1:0]     sdram_ba,
   input  logic [DATA_W/8-1:0]   sdram_dqm,
   input  logic [DATA_W-1:0]     dq_in,
   output logic [DATA_W-1:0]     dq_out,
   output logic [DATA_W/8-1:0]   dq_oe,
   output logic                  proto_err
);
   localparam int NBANK = 1 << BANK_W;
   localparam int NL    = DATA_W / 8;
   localparam int IDX_W = BANK_W + ROW_W + COL_W;

   typedef enum logic [2:0] {
      C_LMR = 3'b000,
      C_REF = 3'b001,
      C_PRE = 3'b010,
      C_ACT = 3'b011,
      C_WR  = 3'b100,
      C_RD  = 3'b101,
      C_BST = 3'b110,
      C_NOP = 3'b111
   } cmd_e;

   logic [NBANK-1:0]   open_q;
   logic [ROW_W-1:0]   row_q [NBANK];
   logic [1:0]         bl_q;
   logic               cl3_q;
   logic               sw_q;
   logic               bact_q;
   logic               bwr_q;
   logic [BANK_W-1:0]  bbank_q;
   logic [COL_W-1:0]   bcol_q;
   logic [3:0]         bk_q;
   logic [1:0]         pv_q;
   logic [1:0][DATA_W-1:0] pd_q;
   logic [NL-1:0]      dqm_q;
   logic [DATA_W-1:0]  mem [1 << MEM_ADDR_W];

   cmd_e               cmd;
   logic               bank_open;
   logic               any_open;
   logic               lmr_bad;
   logic               err;
   logic               start;
   logic               stop;
   logic               op_en;
   logic               op_wr;
   logic               more;
   logic               flush;
   logic [BANK_W-1:0]  op_bank;
   logic [COL_W-1:0]   op_col0;
   logic [COL_W-1:0]   op_col;
   logic [COL_W-1:0]   cmask;
   logic [3:0]         op_k;
   logic [3:0]         blen;
   logic [IDX_W-1:0]   idx_full;
   logic [MEM_ADDR_W-1:0] idx;
   logic [DATA_W-1:0]  rd_word;
   logic               src_v;
   logic [DATA_W-1:0]  src_d;

   assign cmd = sdram_cs ? C_NOP
              : cmd_e'({sdram_ras, sdram_cas, sdram_we});
   assign bank_open = open_q[sdram_ba];
   assign any_open  = |open_q;
   assign lmr_bad   = any_open || sdram_a[2]
                    || (sdram_a[6:4] != 3'd2 && sdram_a[6:4] != 3'd3);

   always_comb begin
      err = 1'b0;
      case (cmd)
         C_LMR:       err = lmr_bad;
         C_ACT:       err = bank_open;
         C_REF:       err = any_open;
         C_RD, C_WR:  err = !bank_open;
         default:     err = 1'b0;
      endcase
   end

   // A new legal READ/WRITE takes over this edge; BST or closing the
   // burst bank ends the burst without issuing a word on this edge.
   assign start = (cmd == C_RD || cmd == C_WR) && bank_open;
   assign stop  = (cmd == C_BST)
               || (cmd == C_PRE && (sdram_a[10] || sdram_ba == bbank_q));
   assign op_en = start || (bact_q && !stop);
   assign op_wr = start ? (cmd == C_WR) : bwr_q;
   assign op_bank = start ? sdram_ba : bbank_q;
   assign op_col0 = start ? sdram_a[COL_W-1:0] : bcol_q;
   assign op_k    = start ? 4'd0 : bk_q;
   assign blen    = 4'd1 << bl_q;
   assign cmask   = COL_W'(blen - 4'd1);
   assign op_col  = (op_col0 & ~cmask)
                  | ((op_col0 + COL_W'(op_k)) & cmask);
   assign more    = ((op_k + 4'd1) < blen) && !(op_wr && sw_q);
   assign flush   = start && (cmd == C_WR);

   assign idx_full = {op_bank, row_q[op_bank], op_col};
   assign idx      = idx_full[MEM_ADDR_W-1:0];
   assign rd_word  = mem[idx];

   assign src_v = cl3_q ? pv_q[1] : pv_q[0];
   assign src_d = cl3_q ? pd_q[1] : pd_q[0];

   always_ff @(posedge clock) begin
      if (!reset && sdram_cke && op_en && op_wr) begin
         for (int i = 0; i < NL; i++) begin
            if (!sdram_dqm[i]) mem[idx][8*i +: 8] <= dq_in[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         open_q    <= '0;
         for (int b = 0; b < NBANK; b++) row_q[b] <= '0;
         bl_q      <= 2'd0;
         cl3_q     <= 1'b0;
         sw_q      <= 1'b0;
         bact_q    <= 1'b0;
         bwr_q     <= 1'b0;
         bbank_q   <= '0;
         bcol_q    <= '0;
         bk_q      <= '0;
         pv_q      <= '0;
         pd_q      <= '0;
         dqm_q     <= '0;
         dq_out    <= '0;
         dq_oe     <= '0;
         proto_err <= 1'b0;
      end else if (sdram_cke) begin
         proto_err <= err;
         case (cmd)
            C_ACT: begin
               open_q[sdram_ba] <= 1'b1;
               row_q[sdram_ba]  <= sdram_a;
            end
            C_PRE: begin
               if (sdram_a[10]) open_q <= '0;
               else open_q[sdram_ba] <= 1'b0;
            end
            C_LMR: begin
               if (!lmr_bad) begin
                  bl_q  <= sdram_a[1:0];
                  cl3_q <= sdram_a[4];
                  sw_q  <= sdram_a[9];
               end
            end
            default: ;
         endcase
         bact_q <= op_en && more;
         if (start) begin
            bwr_q   <= (cmd == C_WR);
            bbank_q <= sdram_ba;
            bcol_q  <= sdram_a[COL_W-1:0];
         end
         if (op_en) bk_q <= op_k + 4'd1;
         // Both CL stages share one DQM sample: the last stage is always
         // loaded on the edge two before dq_out is sampled.
         dqm_q <= sdram_dqm;
         if (flush) begin
            pv_q  <= '0;
            dq_oe <= '0;
         end else begin
            pv_q <= {pv_q[0], op_en && !op_wr};
            pd_q <= {pd_q[0], rd_word};
            if (src_v) dq_out <= src_d;
            dq_oe <= src_v ? ~dqm_q : '0;
         end
      end
   end
endmodule

// File: tb/tb_sdram_chip_model.sv
// tb_sdram_chip_model: directed bench for the SDRAM device model.
// Outputs are checked 1 time unit after each active clock edge.
module tb_sdram_chip_model;
   localparam logic [2:0] NOP = 3'b111;
   localparam logic [2:0] ACT = 3'b011;
   localparam logic [2:0] RD  = 3'b101;
   localparam logic [2:0] WR  = 3'b100;
   localparam logic [2:0] PRE = 3'b010;
   localparam logic [2:0] REF = 3'b001;
   localparam logic [2:0] LMR = 3'b000;
   localparam logic [2:0] BST = 3'b110;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cke   = 1'b1;
   logic        cs    = 1'b1;
   logic        ras   = 1'b1;
   logic        cas   = 1'b1;
   logic        we    = 1'b1;
   logic [12:0] addr  = '0;
   logic [1:0]  ba    = '0;
   logic [3:0]  dqm   = '0;
   logic [31:0] dqin  = '0;
   logic [31:0] dqout;
   logic [3:0]  oe;
   logic        perr;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   sdram_chip_model dut (
      .clock     (clock),
      .reset     (reset),
      .sdram_cke (cke),
      .sdram_cs  (cs),
      .sdram_ras (ras),
      .sdram_cas (cas),
      .sdram_we  (we),
      .sdram_a   (addr),
      .sdram_ba  (ba),
      .sdram_dqm (dqm),
      .dq_in     (dqin),
      .dq_out    (dqout),
      .dq_oe     (oe),
      .proto_err (perr)
   );

   task automatic step(input logic [2:0] c, input logic [1:0] b,
                       input logic [12:0] a, input logic [3:0] m,
                       input logic [31:0] d);
      cs = 1'b0;
      {ras, cas, we} = c;
      ba = b;
      addr = a;
      dqm = m;
      dqin = d;
      @(posedge clock);
      #1;
   endtask

   task automatic nop(input logic [3:0] m, input logic [31:0] d);
      step(NOP, 2'd0, 13'h0, m, d);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      nop(4'h0, 32'h0);
      nop(4'h0, 32'h0);
      reset = 1'b0;
      checks++;
      if (dqout !== 32'h0) begin
         errors++;
         $display("FAIL rst_dq got %h want 0", dqout);
      end
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL rst_oe got %h want 0", oe);
      end
      checks++;
      if (perr !== 1'b0) begin
         errors++;
         $display("FAIL rst_err got %b want 0", perr);
      end
      step(RD, 2'd0, 13'h004, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b1) begin
         errors++;
         $display("FAIL rst_closed_rd got %b want 1", perr);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (perr !== 1'b0) begin
         errors++;
         $display("FAIL rst_err_pulse got %b want 0", perr);
      end
   endtask

   task automatic test_basic;
      step(LMR, 2'd0, 13'h020, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b0) begin
         errors++;
         $display("FAIL basic_lmr_err got %b want 0", perr);
      end
      step(ACT, 2'd1, 13'h012, 4'h0, 32'h0);
      step(WR, 2'd1, 13'h004, 4'h0, 32'hDEADBEEF);
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL basic_oe_n1 got %h want 0", oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (dqout !== 32'hDEADBEEF || oe !== 4'hF) begin
         errors++;
         $display("FAIL basic_data got %h/%h want deadbeef/f", dqout, oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL basic_oe_n3 got %h want 0", oe);
      end
   endtask

   task automatic test_byte_mask;
      step(WR, 2'd1, 13'h008, 4'h0, 32'hAABBCCDD);
      step(WR, 2'd1, 13'h008, 4'b1010, 32'h11223344);
      step(WR, 2'd1, 13'h009, 4'h0, 32'hAABBCCDD);
      step(WR, 2'd1, 13'h009, 4'b0101, 32'h11223344);
      step(RD, 2'd1, 13'h008, 4'h0, 32'h0);
      step(RD, 2'd1, 13'h009, 4'h0, 32'h0);
      checks++;
      if (dqout !== 32'hAA22CC44 || oe !== 4'hF) begin
         errors++;
         $display("FAIL mask_1010 got %h/%h want aa22cc44/f", dqout, oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (dqout !== 32'h11BB33DD || oe !== 4'hF) begin
         errors++;
         $display("FAIL mask_0101 got %h/%h want 11bb33dd/f", dqout, oe);
      end
      nop(4'h0, 32'h0);
   endtask

   task automatic test_burst;
      logic [31:0] exp [4];
      exp[0] = 32'd3;
      exp[1] = 32'd4;
      exp[2] = 32'd1;
      exp[3] = 32'd2;
      step(PRE, 2'd0, 13'h400, 4'h0, 32'h0);
      step(LMR, 2'd0, 13'h022, 4'h0, 32'h0);
      step(ACT, 2'd1, 13'h012, 4'h0, 32'h0);
      step(WR, 2'd1, 13'h004, 4'h0, 32'd1);
      nop(4'h0, 32'd2);
      nop(4'h0, 32'd3);
      nop(4'h0, 32'd4);
      step(RD, 2'd1, 13'h006, 4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL burst_oe_n1 got %h want 0", oe);
      end
      for (int k = 0; k < 4; k++) begin
         nop(4'h0, 32'h0);
         checks++;
         if (dqout !== exp[k] || oe !== 4'hF) begin
            errors++;
            $display("FAIL burst_w%0d got %h/%h want %h/f",
                     k, dqout, oe, exp[k]);
         end
      end
      nop(4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL burst_end got %h want 0", oe);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp [4];
      exp[0] = 32'd2;
      exp[1] = 32'd3;
      exp[2] = 32'd4;
      exp[3] = 32'd1;
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      step(RD, 2'd1, 13'h005, 4'h0, 32'h0);
      checks++;
      if (dqout !== 32'd1 || oe !== 4'hF) begin
         errors++;
         $display("FAIL b2b_first got %h/%h want 1/f", dqout, oe);
      end
      for (int k = 0; k < 4; k++) begin
         nop(4'h0, 32'h0);
         checks++;
         if (dqout !== exp[k] || oe !== 4'hF) begin
            errors++;
            $display("FAIL b2b_w%0d got %h/%h want %h/f",
                     k, dqout, oe, exp[k]);
         end
      end
      nop(4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL b2b_end got %h want 0", oe);
      end
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      nop(4'h0, 32'h0);
      step(BST, 2'd0, 13'h0, 4'h0, 32'h0);
      checks++;
      if (dqout !== 32'd2 || oe !== 4'hF) begin
         errors++;
         $display("FAIL bst_last got %h/%h want 2/f", dqout, oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL bst_stop got %h want 0", oe);
      end
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      step(WR, 2'd1, 13'h000, 4'hF, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL wr_flush got %h want 0", oe);
      end
      nop(4'hF, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL wr_flush2 got %h want 0", oe);
      end
      nop(4'hF, 32'h0);
      nop(4'hF, 32'h0);
      nop(4'h0, 32'h0);
   endtask

   task automatic test_cl3_dqm;
      step(PRE, 2'd0, 13'h400, 4'h0, 32'h0);
      step(LMR, 2'd0, 13'h030, 4'h0, 32'h0);
      step(ACT, 2'd1, 13'h012, 4'h0, 32'h0);
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL cl3_n1 got %h want 0", oe);
      end
      nop(4'h3, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL cl3_n2 got %h want 0", oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (dqout !== 32'd1 || oe !== 4'hC) begin
         errors++;
         $display("FAIL cl3_data got %h/%h want 1/c", dqout, oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL cl3_end got %h want 0", oe);
      end
      step(PRE, 2'd0, 13'h400, 4'h0, 32'h0);
      step(LMR, 2'd0, 13'h020, 4'h0, 32'h0);
      step(ACT, 2'd1, 13'h012, 4'h0, 32'h0);
      step(RD, 2'd1, 13'h005, 4'hF, 32'h0);
      nop(4'hF, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL cl2_dqm_f got %h want 0", oe);
      end
      step(RD, 2'd1, 13'h006, 4'h3, 32'h0);
      nop(4'h0, 32'h0);
      checks++;
      if (dqout !== 32'd3 || oe !== 4'hC) begin
         errors++;
         $display("FAIL cl2_dqm_3 got %h/%h want 3/c", dqout, oe);
      end
      nop(4'h0, 32'h0);
   endtask

   task automatic test_errors;
      step(RD, 2'd2, 13'h004, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b1 || oe !== 4'h0) begin
         errors++;
         $display("FAIL err_rd_closed got %b/%h want 1/0", perr, oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (perr !== 1'b0 || oe !== 4'h0) begin
         errors++;
         $display("FAIL err_rd_after got %b/%h want 0/0", perr, oe);
      end
      step(ACT, 2'd1, 13'h012, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b1) begin
         errors++;
         $display("FAIL err_act_open got %b want 1", perr);
      end
      nop(4'h0, 32'h0);
      step(REF, 2'd0, 13'h0, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b1) begin
         errors++;
         $display("FAIL err_ref_open got %b want 1", perr);
      end
      nop(4'h0, 32'h0);
      step(LMR, 2'd0, 13'h030, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b1) begin
         errors++;
         $display("FAIL err_lmr_open got %b want 1", perr);
      end
      step(PRE, 2'd1, 13'h000, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b0) begin
         errors++;
         $display("FAIL err_pre got %b want 0", perr);
      end
      step(WR, 2'd1, 13'h004, 4'h0, 32'hFFFFFFFF);
      checks++;
      if (perr !== 1'b1) begin
         errors++;
         $display("FAIL err_wr_closed got %b want 1", perr);
      end
      step(LMR, 2'd0, 13'h024, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b1) begin
         errors++;
         $display("FAIL err_lmr_bl got %b want 1", perr);
      end
      step(LMR, 2'd0, 13'h040, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b1) begin
         errors++;
         $display("FAIL err_lmr_cl got %b want 1", perr);
      end
      step(ACT, 2'd1, 13'h012, 4'h0, 32'h0);
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      nop(4'h0, 32'h0);
      checks++;
      if (dqout !== 32'd1 || oe !== 4'hF) begin
         errors++;
         $display("FAIL err_keep got %h/%h want 1/f", dqout, oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL err_bl1 got %h want 0", oe);
      end
   endtask

   task automatic test_cke;
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      cke = 1'b0;
      for (int k = 0; k < 3; k++) begin
         nop(4'h0, 32'h0);
         checks++;
         if (oe !== 4'h0) begin
            errors++;
            $display("FAIL cke_hold%0d got %h want 0", k, oe);
         end
      end
      cke = 1'b1;
      nop(4'h0, 32'h0);
      checks++;
      if (dqout !== 32'd1 || oe !== 4'hF) begin
         errors++;
         $display("FAIL cke_data got %h/%h want 1/f", dqout, oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL cke_end got %h want 0", oe);
      end
   endtask

   task automatic test_reset_mid;
      step(PRE, 2'd0, 13'h400, 4'h0, 32'h0);
      step(LMR, 2'd0, 13'h022, 4'h0, 32'h0);
      step(ACT, 2'd1, 13'h012, 4'h0, 32'h0);
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      nop(4'h0, 32'h0);
      checks++;
      if (dqout !== 32'd1 || oe !== 4'hF) begin
         errors++;
         $display("FAIL rmid_pre got %h/%h want 1/f", dqout, oe);
      end
      reset = 1'b1;
      nop(4'h0, 32'h0);
      reset = 1'b0;
      checks++;
      if (dqout !== 32'h0 || oe !== 4'h0) begin
         errors++;
         $display("FAIL rmid_clr got %h/%h want 0/0", dqout, oe);
      end
      step(RD, 2'd1, 13'h004, 4'h0, 32'h0);
      checks++;
      if (perr !== 1'b1 || oe !== 4'h0) begin
         errors++;
         $display("FAIL rmid_closed got %b/%h want 1/0", perr, oe);
      end
      nop(4'h0, 32'h0);
      checks++;
      if (oe !== 4'h0) begin
         errors++;
         $display("FAIL rmid_noread got %h want 0", oe);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_mask();
      test_burst();
      test_back_to_back();
      test_cl3_dqm();
      test_errors();
      test_cke();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
